// File: rtl/bus_transfer_ctrl.sv
// ============================================================================
// bus_transfer_ctrl: sequences one-word register-to-register moves over a
// shared tri-state bus. Optional transfer counter: define XFER_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_transfer_ctrl #(
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [1:0]      src,
    input  logic [1:0]      dst,
    input  logic [3:0]      bus_in,
    output logic [NREG-1:0] oe,
    output logic [NREG-1:0] en,
    output logic            busy,
    output logic            ack,
    output logic            err,
`ifdef XFER_COUNT_EN
    output logic [7:0]      xfer_cnt,
`endif
    output logic [3:0]      data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      src_q;
    logic [1:0]      dst_q;
    logic [NREG-1:0] oe_q;
    logic [NREG-1:0] en_q;
    logic            busy_q;
    logic            ack_q;
    logic            err_q;
    logic            armed_q;
    logic [3:0]      data_q;
    logic            req_valid;
    logic            sample_d;

    function automatic logic [NREG-1:0] sel(input logic [1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign req_valid = (src != dst) && (int'(src) < NREG) && (int'(dst) < NREG);

    // RELEASE doubles as an IDLE sample point so a held req restarts three
    // cycles after the previous DRIVE while oe stays low for that one cycle.
    // armed_q blocks acceptance at the first edge after reset release.
    assign sample_d = req && armed_q && ((state_q == IDLE) || (state_q == RELEASE));

`ifdef XFER_COUNT_EN
    logic [7:0] cnt_q;
    assign xfer_cnt = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= 2'd0;
            dst_q   <= 2'd0;
            oe_q    <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= 4'h0;
`ifdef XFER_COUNT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE, RELEASE: begin
                    oe_q    <= '0;
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (sample_d) begin
                        if (req_valid) begin
                            src_q   <= src;
                            dst_q   <= dst;
                            oe_q    <= sel(src);
                            busy_q  <= 1'b1;
                            state_q <= DRIVE;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    oe_q    <= sel(src_q);
                    en_q    <= sel(dst_q);
                    state_q <= LOAD;
                end
                LOAD: begin
                    oe_q    <= '0;
                    en_q    <= '0;
                    ack_q   <= 1'b1;
                    data_q  <= bus_in;
                    state_q <= RELEASE;
`ifdef XFER_COUNT_EN
                    cnt_q   <= cnt_q + 8'd1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oe       = oe_q;
    assign en       = en_q;
    assign busy     = busy_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign data_out = data_q;

endmodule

`default_nettype wire
